// File: rtl/usr_pkg.sv
// Shared types for the universal shift register family: operation codes and step classification.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5
  } mode_e;

  // Codes 6 and 7 are not steps; they fall through to hold behaviour.
  function automatic logic is_step(input mode_e m);
    case (m)
      SHL, SHR, ROL, ROR: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Counts shift steps modulo WIDTH and pulses done for one cycle after each wrap.
module shift_bit_counter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic at_last;

  assign at_last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      // done is recomputed every cycle so it can only ever be a single-cycle pulse.
      done <= step && at_last;
      if (clr)
        cnt <= '0;
      else if (step)
        cnt <= at_last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, bidirectional shift, rotate, with a word-completion counter.
import usr_pkg::*;

module univ_shift_reg #(
  parameter int DATA_WIDTH = 8,
  localparam int CNT_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  usr_pkg::mode_e        mode,
  input  logic [DATA_WIDTH-1:0] par_in,
  input  logic                  ser_in_r,
  input  logic                  ser_in_l,
  output logic [DATA_WIDTH-1:0] par_out,
  output logic                  ser_out_l,
  output logic                  ser_out_r,
  output logic [CNT_W-1:0]      bit_cnt,
  output logic                  word_done
);

  logic [DATA_WIDTH-1:0] q;
  logic                  cnt_clr;
  logic                  cnt_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      case (mode)
        LOAD:    q <= par_in;
        SHL:     q <= {q[DATA_WIDTH-2:0], ser_in_r};
        SHR:     q <= {ser_in_l, q[DATA_WIDTH-1:1]};
        ROL:     q <= {q[DATA_WIDTH-2:0], q[DATA_WIDTH-1]};
        ROR:     q <= {q[0], q[DATA_WIDTH-1:1]};
        default: q <= q;
      endcase
    end
  end

  assign cnt_clr  = en && (mode == LOAD);
  assign cnt_step = en && is_step(mode);

  shift_bit_counter #(
    .WIDTH (DATA_WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .step  (cnt_step),
    .cnt   (bit_cnt),
    .done  (word_done)
  );

  assign par_out   = q;
  assign ser_out_l = q[DATA_WIDTH-1];
  assign ser_out_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios followed by random traffic against a reference model.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  usr_pkg::mode_e mode;
  logic [W-1:0]  par_in;
  logic          ser_in_r;
  logic          ser_in_l;
  logic [W-1:0]  par_out;
  logic          ser_out_l;
  logic          ser_out_r;
  logic [CW-1:0] bit_cnt;
  logic          word_done;

  int checks   = 0;
  int failures = 0;

  // Reference state: register value as a number, plus total steps since last load/reset.
  logic [W-1:0] m_q;
  int           m_steps;
  logic         m_done;

  univ_shift_reg #(
    .DATA_WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .par_in    (par_in),
    .ser_in_r  (ser_in_r),
    .ser_in_l  (ser_in_l),
    .par_out   (par_out),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r),
    .bit_cnt   (bit_cnt),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input int m,
                              input logic [W-1:0] p, input logic sr, input logic sl);
    m_done = 1'b0;
    if (r) begin
      m_q     = '0;
      m_steps = 0;
    end else if (e) begin
      case (m)
        1: begin m_q = p; m_steps = 0; end
        2: m_q = W'((int'(m_q) * 2 + int'(sr)) % (1 << W));
        3: m_q = W'(int'(m_q) / 2 + int'(sl) * (1 << (W - 1)));
        4: m_q = W'((int'(m_q) * 2) % (1 << W) + int'(m_q) / (1 << (W - 1)));
        5: m_q = W'(int'(m_q) / 2 + (int'(m_q) % 2) * (1 << (W - 1)));
        default: ;
      endcase
      if (m >= 2 && m <= 5) begin
        m_steps++;
        m_done = (m_steps % W) == 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".par_out"},   32'(par_out),   32'(m_q));
    check({tag, ".ser_out_l"}, 32'(ser_out_l), 32'(m_q[W-1]));
    check({tag, ".ser_out_r"}, 32'(ser_out_r), 32'(m_q[0]));
    check({tag, ".bit_cnt"},   32'(bit_cnt),   32'(m_steps % W));
    check({tag, ".word_done"}, 32'(word_done), 32'(m_done));
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic drive(input string tag, input logic r, input logic e, input int m,
                       input logic [W-1:0] p, input logic sr, input logic sl);
    reset    = r;
    en       = e;
    mode     = usr_pkg::mode_e'(m[2:0]);
    par_in   = p;
    ser_in_r = sr;
    ser_in_l = sl;
    @(posedge clk);
    model_update(r, e, m, p, sr, sl);
    #1;
    check_all(tag);
  endtask

  logic [7:0] pat;
  int         done_count;

  initial begin
    m_q = '0; m_steps = 0; m_done = 1'b0;
    reset = 1'b1; en = 1'b0; mode = usr_pkg::HOLD;
    par_in = '0; ser_in_r = 1'b0; ser_in_l = 1'b0;
    @(negedge clk);

    drive("rst0", 1, 1, 1, 8'h5A, 1, 1);
    drive("rst1", 1, 1, 2, 8'h5A, 1, 1);
    check("rst_par_out", 32'(par_out), 32'h0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'h0);

    drive("load_a5", 0, 1, 1, 8'hA5, 0, 0);
    check("load_a5_val", 32'(par_out), 32'hA5);
    for (int i = 0; i < 3; i++) drive("hold", 0, 1, 0, 8'h00, 1, 1);
    check("hold_a5_val", 32'(par_out), 32'hA5);

    drive("load_00", 0, 1, 1, 8'h00, 0, 0);
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) drive("shl_pat", 0, 1, 2, 8'h00, pat[i], 0);
    check("shl_b2", 32'(par_out), 32'hB2);
    check("shl_done", 32'(word_done), 32'h1);
    check("shl_cnt0", 32'(bit_cnt), 32'h0);
    drive("post_done", 0, 1, 0, 8'h00, 0, 0);
    check("done_one_cycle", 32'(word_done), 32'h0);

    drive("load_81", 0, 1, 1, 8'h81, 0, 0);
    drive("ror", 0, 1, 5, 8'h00, 0, 0);
    check("ror_c0", 32'(par_out), 32'hC0);
    drive("rol", 0, 1, 4, 8'h00, 0, 0);
    drive("rol", 0, 1, 4, 8'h00, 0, 0);
    check("rol_03", 32'(par_out), 32'h03);
    drive("shr", 0, 1, 3, 8'h00, 0, 1);
    check("shr_81", 32'(par_out), 32'h81);
    check("mix_cnt4", 32'(bit_cnt), 32'h4);

    drive("load_0f", 0, 1, 1, 8'h0F, 0, 0);
    for (int i = 0; i < 4; i++) drive("stall_a", 0, 1, 2, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive("stall_en0", 0, 0, 2, 8'hFF, 1, 1);
      check("stall_no_done", 32'(word_done), 32'h0);
    end
    for (int i = 0; i < 4; i++) drive("stall_b", 0, 1, 2, 8'h00, 0, 0);
    check("stall_done", 32'(word_done), 32'h1);
    check("stall_zero", 32'(par_out), 32'h00);

    for (int i = 0; i < 7; i++) drive("bnd_step", 0, 1, 4, 8'h00, 0, 0);
    check("bnd_cnt7", 32'(bit_cnt), 32'h7);
    drive("bnd_load", 0, 1, 1, 8'hFF, 0, 0);
    check("bnd_load_nodone", 32'(word_done), 32'h0);
    check("bnd_load_cnt", 32'(bit_cnt), 32'h0);
    drive("mode6", 0, 1, 6, 8'h00, 0, 0);
    check("mode6_hold", 32'(par_out), 32'hFF);
    drive("mode7", 0, 1, 7, 8'h00, 0, 0);

    for (int i = 0; i < 5; i++) drive("mid_shl", 0, 1, 2, 8'h00, 1, 0);
    drive("mid_rst", 1, 1, 2, 8'h00, 1, 0);
    check("mid_rst_cnt", 32'(bit_cnt), 32'h0);
    check("mid_rst_q", 32'(par_out), 32'h0);
    done_count = 0;
    for (int i = 0; i < 8; i++) begin
      drive("word_shl", 0, 1, 2, 8'h00, 1, 0);
      if (word_done) done_count++;
    end
    drive("word_tail", 0, 1, 0, 8'h00, 0, 0);
    if (word_done) done_count++;
    check("word_done_count", 32'(done_count), 32'h1);

    for (int i = 0; i < 2000; i++) begin
      logic r, e;
      int   m;
      r = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 7) != 0);
      m = (($urandom_range(0, 9) == 0) ? 1 : int'($urandom_range(0, 7)));
      drive("rand", r, e, m, W'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
